mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 64, width of all address ports.
REQ-002 Parameter: MAX_DSTREAK, default 4, maximum consecutive data grants while a fetch request waits.
REQ-003 Ports (name  direction  width  meaning):
- clock  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset
- if_req_i  input  1  fetch request
- if_addr_i  input  ADDR_W  fetch address
- if_gnt_o  output  1  fetch request accepted
- if_rvalid_o  output  1  fetch data valid
- if_rdata_o  output  32  fetched instruction
- d_req_i  input  1  data request
- d_we_i  input  1  1 = store, 0 = load
- d_addr_i  input  ADDR_W  data address
- d_wdata_i  input  64  store data
- d_wstrb_i  input  8  store byte strobes
- d_gnt_o  output  1  data request accepted
- d_rvalid_o  output  1  load data valid or store done
- d_rdata_o  output  64  load data
- m_req_o  output  1  memory request
- m_we_o  output  1  memory write
- m_addr_o  output  ADDR_W  memory address
- m_wdata_o  output  64  memory write data
- m_wstrb_o  output  8  memory strobes
- m_gnt_i  input  1  memory accepted request
- m_rvalid_i  input  1  memory response; writes also respond
- m_rdata_i  input  64  memory read data

Function
REQ-004 The block SHALL allow exactly one outstanding memory transaction.
REQ-005 The FSM SHALL have three states:
- IDLE
- REQ: m_req_o high until m_gnt_i
- WAIT: until m_rvalid_i
REQ-006 In IDLE with any request present, the block SHALL assert exactly one gnt for one cycle, register that requester's address, we, wdata and wstrb plus an owner bit, and move to REQ next cycle.
- For a fetch, the block SHALL register we=0 and wstrb=0.
REQ-007 Priority: data SHALL win over fetch, except fetch SHALL win when the streak counter equals MAX_DSTREAK.
REQ-008 Streak counter:
- SHALL increment on each data grant made while if_req_i is high.
- SHALL clear on a fetch grant.
- SHALL saturate at MAX_DSTREAK.
REQ-009 Requesters SHALL hold req and payload stable until gnt; payload changes after gnt SHALL NOT affect the issued transaction.
REQ-010 In REQ, the block SHALL drive m_req_o=1 with the registered payload, and go to WAIT on the cycle m_gnt_i=1.
REQ-011 In WAIT, on m_rvalid_i=1, the block SHALL assert the owner's rvalid in the same cycle (combinational) and return to IDLE next cycle.
REQ-012 Read data routing:
- d_rdata_o SHALL equal m_rdata_i.
- if_rdata_o SHALL be m_rdata_i[31:0] when registered addr[2]=0, else m_rdata_i[63:32].
REQ-013 m_rvalid_i in IDLE or REQ SHALL be ignored: no rvalid output asserted.
REQ-014 gnt outputs SHALL be 0 outside IDLE; requests arriving while busy wait.
REQ-015 Minimum latency: gnt at cycle 0, m_req_o at cycle 1, rvalid at cycle 2 when m_gnt_i is at cycle 1 and m_rvalid_i is at cycle 2.
REQ-016 m_req_o SHALL never be high in IDLE or WAIT.

Reset
REQ-017 On reset low, asynchronously:
- state SHALL go to IDLE.
- streak SHALL be 0 and owner SHALL be fetch.
- m_req_o, m_we_o, all gnt and all rvalid outputs SHALL be 0.
- m_addr_o, m_wdata_o and m_wstrb_o SHALL be 0.
REQ-018 Reset during REQ or WAIT SHALL abandon the transaction; a later m_rvalid_i SHALL be ignored per REQ-013.

Structure
REQ-019 The state enum and the MAX_DSTREAK default SHALL live in shared package rv_mem_pkg.
REQ-020 The block SHALL be a single module with no sub-module.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Fetch only: if_addr=0x80000004, m_gnt_i at cycle 1, m_rdata=0x11112222_33334444 at cycle 2 -> if_rvalid_o at cycle 2, if_rdata_o=0x11112222.
- Simultaneous if_req and d_req (load 0x1000): d_gnt_o first; the fetch is granted in the first IDLE after d_rvalid_o.
- Starvation: d_req held high for 6 transactions with if_req high -> 4 data grants, then a fetch grant, then data grants resume.
- Store: d_we=1, wstrb=0x0F, wdata=0xDEADBEEF -> m_we_o=1, m_wstrb_o=0x0F; d_rvalid_o pulses on m_rvalid_i; if_rvalid_o stays 0.
- m_gnt_i withheld 5 cycles -> m_req_o and payload stable all 5 cycles; no gnt outputs during that time.
- Reset low in WAIT, then m_rvalid_i pulse after release -> no rvalid output; state IDLE; next request is served normally.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared definitions for the instruction/data memory-port arbiter:
// FSM states, request owner encoding and the data-streak default.
package rv_mem_pkg;

  localparam int MAX_DSTREAK_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-master (fetch/data) arbiter onto a single memory port with one outstanding
// transaction; data has priority but a waiting fetch is served after MAX_DSTREAK data grants.
module mem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int MAX_DSTREAK = MAX_DSTREAK_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [63:0]       d_wdata_i,
  input  logic [7:0]        d_wstrb_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [63:0]       d_rdata_o,
  output logic              m_req_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [63:0]       m_wdata_o,
  output logic [7:0]        m_wstrb_o,
  input  logic              m_gnt_i,
  input  logic              m_rvalid_i,
  input  logic [63:0]       m_rdata_i
);

  localparam int              SW         = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_DSTREAK);

  arb_state_e        state_q,  state_d;
  owner_e            owner_q,  owner_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic              we_q,     we_d;
  logic [63:0]       wdata_q,  wdata_d;
  logic [7:0]        wstrb_q,  wstrb_d;

  logic if_gnt;
  logic d_gnt;
  logic fetch_wins;
  logic rsp_valid;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    owner_d    = owner_q;
    streak_d   = streak_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    fetch_wins = if_req_i && (!d_req_i || (streak_q == STREAK_MAX));

    unique case (state_q)
      ST_IDLE: begin
        if (fetch_wins) begin
          if_gnt   = 1'b1;
          owner_d  = OWN_FETCH;
          addr_d   = if_addr_i;
          we_d     = 1'b0;
          wdata_d  = '0;
          wstrb_d  = '0;
          streak_d = '0;
          state_d  = ST_REQ;
        end else if (d_req_i) begin
          d_gnt   = 1'b1;
          owner_d = OWN_DATA;
          addr_d  = d_addr_i;
          we_d    = d_we_i;
          wdata_d = d_wdata_i;
          wstrb_d = d_wstrb_i;
          state_d = ST_REQ;
          // Only data grants that overtake a waiting fetch count towards its starvation limit.
          if (if_req_i && (streak_q != STREAK_MAX)) streak_d = streak_q + SW'(1);
        end
      end
      ST_REQ: begin
        if (m_gnt_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (m_rvalid_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_FETCH;
      streak_q <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
    end
  end

  // Grants answer live requests in the same cycle, so they are masked while reset is held.
  assign if_gnt_o = if_gnt & reset;
  assign d_gnt_o  = d_gnt & reset;

  assign m_req_o   = (state_q == ST_REQ);
  assign m_we_o    = we_q;
  assign m_addr_o  = addr_q;
  assign m_wdata_o = wdata_q;
  assign m_wstrb_o = wstrb_q;

  // Responses outside WAIT are stray (e.g. from an abandoned transaction) and are dropped.
  assign rsp_valid   = (state_q == ST_WAIT) && m_rvalid_i;
  assign if_rvalid_o = rsp_valid && (owner_q == OWN_FETCH);
  assign d_rvalid_o  = rsp_valid && (owner_q == OWN_DATA);

  assign d_rdata_o  = m_rdata_i;
  assign if_rdata_o = addr_q[2] ? m_rdata_i[63:32] : m_rdata_i[31:0];

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by randomized
// request/memory traffic scored against a transaction-level arbitration model.
module tb_mem_arbiter;
  import rv_mem_pkg::*;

  localparam int ADDR_W = 64;
  localparam int MAXS   = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              if_req_i = 1'b0;
  logic [ADDR_W-1:0] if_addr_i = '0;
  logic              if_gnt_o, if_rvalid_o;
  logic [31:0]       if_rdata_o;
  logic              d_req_i = 1'b0, d_we_i = 1'b0;
  logic [ADDR_W-1:0] d_addr_i = '0;
  logic [63:0]       d_wdata_i = '0;
  logic [7:0]        d_wstrb_i = '0;
  logic              d_gnt_o, d_rvalid_o;
  logic [63:0]       d_rdata_o;
  logic              m_req_o, m_we_o;
  logic [ADDR_W-1:0] m_addr_o;
  logic [63:0]       m_wdata_o;
  logic [7:0]        m_wstrb_o;
  logic              m_gnt_i = 1'b0, m_rvalid_i = 1'b0;
  logic [63:0]       m_rdata_i = '0;

  mem_arbiter #(.ADDR_W(ADDR_W), .MAX_DSTREAK(MAXS)) dut (
    .clock(clock), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_wstrb_i(d_wstrb_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_wstrb_o(m_wstrb_o), .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i)
  );

  always #5 clock = ~clock;

  typedef enum int {W_NONE, W_FETCH, W_DATA} who_e;
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [63:0]       wdata;
    logic [7:0]        wstrb;
    who_e              owner;
  } txn_t;

  int   checks = 0;
  int   errors = 0;
  int   streak = 0;   // model: data grants made while a fetch waited
  txn_t cur;          // model: transaction the memory port should be carrying
  who_e w;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // IDLE-cycle arbitration: predict the winner from the priority rules, check the grants,
  // capture the expected payload and advance the model's streak count.
  task automatic arbitrate(output who_e win);
    if (if_req_i && (!d_req_i || streak == MAXS)) win = W_FETCH;
    else if (d_req_i)                             win = W_DATA;
    else                                          win = W_NONE;
    @(negedge clock);
    check("if_gnt", 64'(if_gnt_o), 64'(win == W_FETCH));
    check("d_gnt", 64'(d_gnt_o), 64'(win == W_DATA));
    check("m_req_idle", 64'(m_req_o), 64'(0));
    if (win == W_FETCH) begin
      cur.addr = if_addr_i; cur.we = 1'b0; cur.wdata = '0; cur.wstrb = '0; cur.owner = W_FETCH;
      streak = 0;
    end else if (win == W_DATA) begin
      cur.addr = d_addr_i; cur.we = d_we_i; cur.wdata = d_wdata_i; cur.wstrb = d_wstrb_i;
      cur.owner = W_DATA;
      if (if_req_i && streak < MAXS) streak++;
    end
    next_cycle();
  endtask

  // Memory side of one transaction: m_gnt_i after gd REQ cycles, m_rvalid_i after rd WAIT cycles.
  task automatic serve(input int gd, input int rd, input logic [63:0] rdata, input bit spurious);
    for (int k = 0; k <= gd; k++) begin
      m_gnt_i    = (k == gd);
      m_rvalid_i = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      m_rdata_i  = {$urandom, $urandom};
      @(negedge clock);
      check("m_req", 64'(m_req_o), 64'(1));
      check("m_addr", 64'(m_addr_o), 64'(cur.addr));
      check("m_we", 64'(m_we_o), 64'(cur.we));
      check("m_wstrb", 64'(m_wstrb_o), 64'(cur.wstrb));
      if (cur.owner == W_DATA) check("m_wdata", m_wdata_o, cur.wdata);
      check("busy_gnt", 64'({if_gnt_o, d_gnt_o}), 64'(0));
      check("req_rvalid", 64'({if_rvalid_o, d_rvalid_o}), 64'(0));
      next_cycle();
    end
    m_gnt_i = 1'b0;
    for (int k = 0; k <= rd; k++) begin
      m_rvalid_i = (k == rd);
      m_rdata_i  = (k == rd) ? rdata : {$urandom, $urandom};
      @(negedge clock);
      check("wait_m_req", 64'(m_req_o), 64'(0));
      check("wait_gnt", 64'({if_gnt_o, d_gnt_o}), 64'(0));
      check("if_rvalid", 64'(if_rvalid_o), 64'((k == rd) && cur.owner == W_FETCH));
      check("d_rvalid", 64'(d_rvalid_o), 64'((k == rd) && cur.owner == W_DATA));
      if (k == rd && cur.owner == W_FETCH)
        check("if_rdata", 64'(if_rdata_o), 64'(cur.addr[2] ? rdata[63:32] : rdata[31:0]));
      if (k == rd && cur.owner == W_DATA)
        check("d_rdata", d_rdata_o, rdata);
      next_cycle();
    end
    m_rvalid_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state with every request and memory input active.
    reset = 1'b0; if_req_i = 1'b1; d_req_i = 1'b1; m_gnt_i = 1'b1; m_rvalid_i = 1'b1;
    if_addr_i = 64'h1234; d_addr_i = 64'h5678; d_we_i = 1'b1; d_wdata_i = 64'hFF; d_wstrb_i = 8'hFF;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_gnt", 64'({if_gnt_o, d_gnt_o}), 64'(0));
    check("rst_rvalid", 64'({if_rvalid_o, d_rvalid_o}), 64'(0));
    check("rst_m_req", 64'(m_req_o), 64'(0));
    check("rst_m_we", 64'(m_we_o), 64'(0));
    check("rst_m_addr", 64'(m_addr_o), 64'(0));
    check("rst_m_wdata", m_wdata_o, 64'(0));
    check("rst_m_wstrb", 64'(m_wstrb_o), 64'(0));
    next_cycle();
    if_req_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0; m_gnt_i = 1'b0; m_rvalid_i = 1'b0;
    reset = 1'b1;
    streak = 0;
    next_cycle();

    // Fetch only, minimum latency, upper word selected by addr[2].
    if_req_i = 1'b1; if_addr_i = 64'h8000_0004;
    arbitrate(w);
    if_req_i = 1'b0; if_addr_i = 64'hFFFF_FFF0;
    serve(0, 0, 64'h1111_2222_3333_4444, 1'b0);

    // Simultaneous load and fetch: data first, fetch in the next IDLE.
    if_req_i = 1'b1; if_addr_i = 64'h8000_0008;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 64'h1000; d_wdata_i = '0; d_wstrb_i = '0;
    arbitrate(w);
    d_req_i = 1'b0; d_addr_i = 64'hBAD0;
    serve(1, 1, 64'hA5A5_0000_5A5A_FFFF, 1'b0);
    arbitrate(w);
    if_req_i = 1'b0;
    serve(0, 0, 64'h0123_4567_89AB_CDEF, 1'b0);

    // Starvation: data held for six arbitrations with a fetch waiting.
    if_req_i = 1'b1; if_addr_i = 64'h8000_0100;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 64'h2000;
    for (int i = 0; i < 6; i++) begin
      arbitrate(w);
      if (w == W_FETCH) if_req_i = 1'b0;
      else d_addr_i = d_addr_i + 64'h8;
      serve(0, 0, {$urandom, $urandom}, 1'b0);
    end
    d_req_i = 1'b0;

    // Store: write payload reaches the memory port, only d_rvalid_o responds.
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 64'h3000;
    d_wdata_i = 64'h0000_0000_DEAD_BEEF; d_wstrb_i = 8'h0F;
    arbitrate(w);
    d_req_i = 1'b0; d_we_i = 1'b0; d_wdata_i = '0; d_wstrb_i = '0;
    serve(0, 1, {$urandom, $urandom}, 1'b0);

    // Memory grant withheld five cycles while both requesters wait.
    if_req_i = 1'b1; if_addr_i = 64'h8000_0200;
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 64'h4000; d_wdata_i = 64'hCAFE; d_wstrb_i = 8'hF0;
    arbitrate(w);
    d_req_i = 1'b0; d_we_i = 1'b0;
    serve(5, 0, {$urandom, $urandom}, 1'b0);
    arbitrate(w);
    if_req_i = 1'b0;
    serve(0, 2, {$urandom, $urandom}, 1'b0);

    // Reset while waiting for a response; the late response must be dropped.
    if_req_i = 1'b1; if_addr_i = 64'h40;
    arbitrate(w);
    if_req_i = 1'b0;
    m_gnt_i = 1'b1;
    @(negedge clock);
    check("rst_txn_m_req", 64'(m_req_o), 64'(1));
    next_cycle();
    m_gnt_i = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_wait_m_req", 64'(m_req_o), 64'(0));
    check("rst_wait_m_addr", 64'(m_addr_o), 64'(0));
    next_cycle();
    reset = 1'b1; streak = 0;
    m_rvalid_i = 1'b1; m_rdata_i = 64'h7777_8888_9999_AAAA;
    @(negedge clock);
    check("stray_rvalid", 64'({if_rvalid_o, d_rvalid_o}), 64'(0));
    next_cycle();
    m_rvalid_i = 1'b0;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 64'h5000;
    arbitrate(w);
    d_req_i = 1'b0;
    serve(1, 2, 64'h1357_9BDF_2468_ACE0, 1'b0);

    // Random traffic: requests hold until granted, payloads change after the grant.
    for (int n = 0; n < 150; n++) begin
      if (!if_req_i && $urandom_range(0, 2) != 0) begin
        if_req_i = 1'b1; if_addr_i = {$urandom, $urandom};
      end
      if (!d_req_i && $urandom_range(0, 3) != 0) begin
        d_req_i = 1'b1; d_we_i = 1'($urandom); d_addr_i = {$urandom, $urandom};
        d_wdata_i = {$urandom, $urandom}; d_wstrb_i = 8'($urandom);
      end
      arbitrate(w);
      if (w == W_FETCH) begin
        if_req_i = 1'b0; if_addr_i = {$urandom, $urandom};
      end else if (w == W_DATA) begin
        d_req_i = 1'b0; d_addr_i = {$urandom, $urandom}; d_wdata_i = {$urandom, $urandom};
        d_wstrb_i = 8'($urandom); d_we_i = 1'($urandom);
      end
      if (w != W_NONE)
        serve($urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom}, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
